// File: rtl/conv_channel_err_inj_if.sv
// Symbol stream between the convolutional encoder, the channel model and the
// Viterbi decoder: the encoder-side symbol in, the possibly corrupted symbol out.
interface conv_channel_err_inj_if #(
    parameter int SYM_W = 2
) ();
    logic             valid_i;
    logic [SYM_W-1:0] sym_i;
    logic             valid_o;
    logic [SYM_W-1:0] sym_o;
    logic             err_o;

    // Source/sink side: drives encoder symbols, observes the channel output.
    modport master (
        output valid_i, sym_i,
        input  valid_o, sym_o, err_o
    );

    // Channel model side.
    modport slave (
        input  valid_i, sym_i,
        output valid_o, sym_o, err_o
    );
endinterface

// File: rtl/conv_channel_err_inj.sv
// Channel model for the encoder -> Viterbi path. Registers each coded symbol
// and XORs a mask into selected symbols under a clean, periodic, burst or
// LFSR-random pattern, with per-symbol error flags and saturating statistics.
module conv_channel_err_inj #(
    parameter int                SYM_W  = 2,
    parameter int                PH_W   = 8,
    parameter int                CNT_W  = 16,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    input  logic [PH_W-1:0]      period_i,
    input  logic [PH_W-1:0]      burst_len_i,
    input  logic [LFSR_W-1:0]    thresh_i,
    input  logic [SYM_W-1:0]     err_mask_i,
    input  logic [CNT_W-1:0]     win_len_i,
    conv_channel_err_inj_if.slave sif,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     inj_ct_o,
    output logic [CNT_W-1:0]     flip_ct_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
    typedef enum logic [1:0] {M_CLEAN, M_PERIODIC, M_BURST, M_RANDOM} mode_e;

    state_e            state_q, state_d;
    mode_e             mode_q;
    logic [PH_W-1:0]   period_q, burst_len_q, phase_q, phase_nxt;
    logic [LFSR_W-1:0] thresh_q, lfsr_q, lfsr_nxt;
    logic [SYM_W-1:0]  mask_q;
    logic [CNT_W-1:0]  win_len_q, k_q, inj_ct_q, flip_ct_q, inj_ct_nxt, flip_ct_nxt;
    logic [CNT_W:0]    inj_sum, flip_sum;
    logic              hit, inj, err_nxt, last_sym;

    function automatic logic [CNT_W-1:0] popcount(input logic [SYM_W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < SYM_W; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    // Pattern hit for the current symbol, injection gate and window end.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        hit = 1'b0;
        case (mode_q)
            M_PERIODIC: hit = (period_q != '0) && (phase_q == period_q - PH_W'(1));
            M_BURST:    hit = (period_q != '0) && (phase_q < burst_len_q);
            M_RANDOM:   hit = (lfsr_q < thresh_q);
            default:    hit = 1'b0;
        endcase
        // The start cycle never injects: it belongs to the new run, not the old one.
        inj      = (state_q == S_RUN) && !start_i && hit;
        err_nxt  = inj && sif.valid_i && (mask_q != '0);
        last_sym = (state_q == S_RUN) && sif.valid_i && (win_len_q != '0)
                   && (k_q == win_len_q - CNT_W'(1));
    end

    // Phase wrap, Galois LFSR step and saturating statistics increments.
    always_comb begin
        phase_nxt = ((period_q == '0) || (phase_q == period_q - PH_W'(1)))
                    ? '0 : phase_q + PH_W'(1);
        lfsr_nxt  = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        inj_sum   = {1'b0, inj_ct_q} + (CNT_W+1)'(1);
        flip_sum  = {1'b0, flip_ct_q} + {1'b0, popcount(mask_q)};
        inj_ct_nxt  = inj_sum[CNT_W]  ? '1 : inj_sum[CNT_W-1:0];
        flip_ct_nxt = flip_sum[CNT_W] ? '1 : flip_sum[CNT_W-1:0];
    end

    // Next state: start always (re)enters RUN and beats a simultaneous window end.
    always_comb begin
        state_d = state_q;
        if (start_i)       state_d = S_RUN;
        else if (last_sym) state_d = S_DONE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Output register, config capture and run counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sif.valid_o <= 1'b0;
            sif.sym_o   <= '0;
            sif.err_o   <= 1'b0;
            mode_q      <= M_CLEAN;
            period_q    <= '0;
            burst_len_q <= '0;
            thresh_q    <= '0;
            mask_q      <= '0;
            win_len_q   <= '0;
            k_q         <= '0;
            phase_q     <= '0;
            lfsr_q      <= SEED;
            inj_ct_q    <= '0;
            flip_ct_q   <= '0;
        end else begin
            sif.valid_o <= sif.valid_i;
            sif.sym_o   <= sif.sym_i ^ (inj ? mask_q : '0);
            sif.err_o   <= err_nxt;
            if (start_i) begin
                mode_q      <= mode_e'(mode_i);
                period_q    <= period_i;
                burst_len_q <= burst_len_i;
                thresh_q    <= thresh_i;
                mask_q      <= err_mask_i;
                win_len_q   <= win_len_i;
                k_q         <= '0;
                phase_q     <= '0;
                lfsr_q      <= SEED;
                inj_ct_q    <= '0;
                flip_ct_q   <= '0;
            end else if ((state_q == S_RUN) && sif.valid_i) begin
                k_q     <= k_q + CNT_W'(1);
                phase_q <= phase_nxt;
                lfsr_q  <= lfsr_nxt;
                if (err_nxt) begin
                    inj_ct_q  <= inj_ct_nxt;
                    flip_ct_q <= flip_ct_nxt;
                end
            end
        end
    end

    assign busy_o    = (state_q == S_RUN);
    assign inj_ct_o  = inj_ct_q;
    assign flip_ct_o = flip_ct_q;

endmodule

// File: doc/conv_channel_err_inj.md
Name: conv_channel_err_inj

Overview:
- Parametrised channel model between the convolutional encoder output and the Viterbi decoder input.
- Registers coded symbols and flips selected bits under one of four runtime modes: clean, periodic, burst or LFSR-random.
- Provides per-symbol error flags and saturating statistics counters.
- Successor to the fixed single-bit, fixed-period injector, generalised in symbol width, pattern and window length.

Parameters:
- SYM_W, 2, coded symbol width (code rate 1/SYM_W).
- PH_W, 8, width of period/burst configuration and phase counter.
- CNT_W, 16, width of window length and statistics counters.
- LFSR_W, 16, random-mode LFSR width.
- TAPS, 16'hB400, Galois feedback mask (LFSR_W bits).
- SEED, 16'hACE1, LFSR reload value; must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- start_i  in  1  one-cycle pulse: capture config, clear stats, enter RUN
- mode_i  in  2  0 clean, 1 periodic, 2 burst, 3 random
- period_i  in  PH_W  pattern period in symbols
- burst_len_i  in  PH_W  corrupted symbols per period (burst mode)
- thresh_i  in  LFSR_W  random mode: inject when lfsr < thresh
- err_mask_i  in  SYM_W  bits XORed into a corrupted symbol
- win_len_i  in  CNT_W  symbols subject to injection; 0 = unlimited
- valid_i  in  1  input symbol valid
- sym_i  in  SYM_W  encoder symbol
- valid_o  out  1  output symbol valid
- sym_o  out  SYM_W  possibly corrupted symbol
- err_o  out  1  sym_o is corrupted this cycle
- busy_o  out  1  state == RUN
- inj_ct_o  out  CNT_W  corrupted symbols since start, saturating
- flip_ct_o  out  CNT_W  flipped bits since start, saturating

Behaviour:
- Reset values: all outputs 0; state IDLE; lfsr = SEED; phase, symbol index k and config registers cleared.
- Latency: exactly 1 clock. valid_o(t+1) = valid_i(t); sym_o(t+1) = sym_i(t) ^ (inj ? mask_q : 0); err_o(t+1) = inj && valid_i(t) && (mask_q != 0).
- No backpressure. Bubbles pass through. Phase, k and lfsr advance only on valid_i.
- States:
  - IDLE: clean passthrough.
  - RUN: injection active.
  - DONE: clean passthrough, stats held.
- Transitions:
  - IDLE -> RUN on start_i.
  - RUN -> DONE after the symbol with k == win_len_q-1 is processed (win_len_q != 0).
  - DONE -> RUN on start_i.
  - start_i in RUN restarts the run.
- On start_i:
  - Capture mode, period, burst_len, thresh, mask and win_len into *_q registers.
  - Zero k, phase, inj_ct and flip_ct; lfsr = SEED.
  - The capture cycle itself injects nothing, even if valid_i is high.
  - Config input changes outside start_i are ignored.
- Injection decision for a RUN symbol with index k:
  - mode 0: never.
  - mode 1: phase == period_q-1.
  - mode 2: phase < burst_len_q. burst_len_q >= period_q means every symbol.
  - mode 3: lfsr < thresh_q. Galois step: lfsr = (lfsr>>1) ^ (lfsr[0] ? TAPS : 0), stepped after each valid symbol. thresh 0 means never.
  - period_q == 0: modes 1/2 never inject.
- Phase counter: 0..period_q-1; wraps to 0 after period_q-1.
- Stats, updated on each corrupted symbol, both saturating at all-ones:
  - inj_ct += 1
  - flip_ct += popcount(mask_q)
- Simultaneous start_i and last-window symbol: start_i wins and that symbol is not injected.
- Reset mid-run: immediate return to reset values; in-flight symbol dropped (valid_o 0).

Test Plan:
- Periodic: start with mode 1, period 16, mask 2'b01, win 256; 300 back-to-back valids -> err_o on k = 15, 31, ..., 255 only; inj_ct 16, flip_ct 16; busy_o low after k 255.
- Burst: mode 2, period 8, burst 3, mask 2'b11, win 16 -> k 0-2 and 8-10 corrupted (both bits inverted); inj_ct 6, flip_ct 12.
- Random: mode 3, thresh 0 -> sym_o == delayed sym_i for 1000 symbols, inj_ct 0. Rerun with thresh 16'h8000 -> error pattern matches a reference LFSR model bit-exactly.
- Bubbles: mode 1, period 4; valid_i high every other cycle -> corrupted symbols are the 4th, 8th, ... valid symbols; valid_o is valid_i delayed 1 cycle.
- Saturation and restart: CNT_W = 4, mode 1, period 1, win 0, 40 symbols -> inj_ct 15 held. Mid-run start_i -> counters 0 next cycle, pattern restarts at k 0.
- Async reset mid-burst: drop rst between clk edges -> valid_o, err_o, sym_o and counters 0 immediately; after release, IDLE passthrough.
